soc_reset_ctrl: RTL



---
 rtl/soc_reset_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/soc_reset_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/soc_reset_pkg.sv
// Shared reset-cause codes, FSM state encoding and a saturating counter helper
// for the SoC reset controller.
package soc_reset_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_BTN = 2'd1,
    CAUSE_SW  = 2'd2,
    CAUSE_WDT = 2'd3
  } cause_t;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debouncer: btn_stable_o follows btn_i after SYNC_STAGES+DEBOUNCE_CYCLES
// cycles of steady disagreement; no handshake, output is a level.
module btn_debounce
  import soc_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic btn_stable_o
);

  localparam logic [CNT_WIDTH-1:0] DEB_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   btn_sync;

  assign btn_sync     = sync_q[SYNC_STAGES-1];
  assign btn_stable_o = stable_q;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (btn_sync != stable_q) begin
      if (cnt_q == DEB_MAX) begin
        stable_d = btn_sync;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/soc_reset_ctrl.sv
// SoC reset controller: async assert, sync release after HOLD_CYCLES, cause + saturating count;
// no backpressure. Optional watchdog source enabled by SOC_RESET_WDT_EN.
module soc_reset_ctrl
  import soc_reset_pkg::*;
#(
  parameter int HOLD_CYCLES     = 256,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SYNC_STAGES     = 2,
`ifdef SOC_RESET_WDT_EN
  parameter int WDT_CYCLES      = 1 << 24,
`endif
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_i,
  input  logic       sw_req_i,
`ifdef SOC_RESET_WDT_EN
  input  logic       wdt_kick_i,
`endif
  output logic       sys_reset_o,
  output logic [1:0] reset_cause_o,
  output logic [7:0] reset_count_o
);

  localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 btn_stable;
  logic                 wdt_fire;
  state_t               state_q;
  cause_t               cause_q;
  logic [CNT_WIDTH-1:0] hold_cnt_q;
  logic [7:0]           count_q;
  logic                 sys_reset_q;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_btn_debounce (
    .clk         (clk),
    .reset       (reset),
    .btn_i       (btn_i),
    .btn_stable_o(btn_stable)
  );

`ifdef SOC_RESET_WDT_EN
  localparam logic [31:0] WDT_MAX = 32'(WDT_CYCLES - 1);
  logic [31:0] wdt_cnt_q;

  // A kick arriving on the expiry cycle wins, so a just-in-time kick never resets.
  assign wdt_fire = (state_q == ST_RUN) && !wdt_kick_i && (wdt_cnt_q == WDT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt_q <= '0;
    end else if (state_q != ST_RUN || wdt_kick_i || wdt_fire) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_q + 32'd1;
    end
  end
`else
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      cause_q     <= CAUSE_POR;
      hold_cnt_q  <= '0;
      count_q     <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // A held button keeps the hold window pinned open.
          if (btn_stable) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_MAX) begin
            state_q     <= ST_RUN;
            sys_reset_q <= 1'b0;
            hold_cnt_q  <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (btn_stable || sw_req_i || wdt_fire) begin
            state_q     <= ST_HOLD;
            sys_reset_q <= 1'b1;
            hold_cnt_q  <= '0;
            count_q     <= sat_inc(count_q);
            if (btn_stable)    cause_q <= CAUSE_BTN;
            else if (sw_req_i) cause_q <= CAUSE_SW;
            else               cause_q <= CAUSE_WDT;
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          sys_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign sys_reset_o   = sys_reset_q;
  assign reset_cause_o = cause_q;
  assign reset_count_o = count_q;

endmodule
